mem_stage_ctrl: RTL and testbench

Pipeline sequencing controller for the EX/MEM latch and its neighbours. It drives the `writeEN`/`flush` pins of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It issues data-memory requests for the instruction held in EX/MEM, freezes the pipeline on cache misses, and squashes younger instructions when a control transfer resolves in MEM. It also latches a sticky halt.

---
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// EX/MEM pipeline sequencing controller: data-memory requests, miss freeze, control-transfer squash, sticky halt.
// Optional stall-cycle counter is built only when MEM_STALL_CNT_EN is defined; otherwise stall_cnt reads 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | pipeline flowing; EX/MEM memory op may hit (advance) or miss
// MEMWAIT | data miss outstanding; pipeline frozen, request held until dhit
// HALTED  | halting instruction has retired; everything idle until RST

module mem_stage_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_dren,
  input  logic             ex_dwen,
  input  logic             ex_halt,
  input  logic             ex_branch,
  input  logic             ex_jtype,
  input  logic             ex_jreg,
  input  logic             ihit,
  input  logic             dhit,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_redirect,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

  state_t state;
  logic   memop;
  logic   xfer;
  logic   adv;

  assign memop = ex_dren | ex_dwen;
  assign xfer  = ex_branch | ex_jtype | ex_jreg;

  always_comb begin
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    adv         = 1'b0;
    ifid_wen    = 1'b0;
    idex_wen    = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_redirect = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          dmemREN = ex_dren;
          dmemWEN = ex_dwen;
          adv     = !memop | dhit;
        end
        MEMWAIT: begin
          dmemREN = ex_dren;
          dmemWEN = ex_dwen;
          adv     = dhit;
        end
        default: adv = 1'b0;
      endcase
    end
    if (adv) begin
      exmem_wen = 1'b1;
      memwb_wen = 1'b1;
      idex_wen  = 1'b1;
      ifid_wen  = ihit;
      if (xfer) begin
        // Squash everything younger than EX/MEM; a flushed latch never also loads.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        pc_redirect = 1'b1;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
      end else if (!ihit) begin
        idex_flush = 1'b1;
        idex_wen   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else if (adv && ex_halt) begin
      state <= HALTED;
    end else if (state == RUN && memop && !dhit) begin
      state <= MEMWAIT;
    end else if (state == MEMWAIT && dhit) begin
      state <= RUN;
    end
  end

  assign halt = (state == HALTED) && !RST;

`ifdef MEM_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (state != HALTED && !exmem_wen && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = RST ? '0 : cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; expected values are hand-derived per scenario.
// Output vector order: dmemREN dmemWEN ifid_wen idex_wen exmem_wen memwb_wen ifid_flush idex_flush exmem_flush pc_redirect halt.

module tb_mem_stage_ctrl;

  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ex_dren, ex_dwen, ex_halt, ex_branch, ex_jtype, ex_jreg, ihit, dhit;
  logic             dmemREN, dmemWEN, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic             ifid_flush, idex_flush, exmem_flush, pc_redirect, halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [10:0]      outs;

  int checks = 0;
  int errors = 0;

`ifdef MEM_STALL_CNT_EN
  localparam logic [CNT_W-1:0] MISS_CNT = 3;
`else
  localparam logic [CNT_W-1:0] MISS_CNT = 0;
`endif

  mem_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .ex_dren(ex_dren), .ex_dwen(ex_dwen), .ex_halt(ex_halt), .ex_branch(ex_branch),
    .ex_jtype(ex_jtype), .ex_jreg(ex_jreg), .ihit(ihit), .dhit(dhit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pc_redirect(pc_redirect), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  assign outs = {dmemREN, dmemWEN, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                 ifid_flush, idex_flush, exmem_flush, pc_redirect, halt};

  task automatic idle();
    ex_dren = 0; ex_dwen = 0; ex_halt = 0; ex_branch = 0;
    ex_jtype = 0; ex_jreg = 0; ihit = 1; dhit = 0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    next_cycle();
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    ex_dren = 1; ex_dwen = 1; ex_halt = 1; ex_branch = 1; dhit = 1; ihit = 1;
    @(negedge CLK);
    checks++;
    if (outs !== 11'b0 || stall_cnt !== '0) begin
      $display("FAIL reset_outputs outs=%b stall=%0d want outs=0 stall=0", outs, stall_cnt);
      errors++;
    end
    next_cycle();
    RST = 0;
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00 || stall_cnt !== '0) begin
      $display("FAIL reset_idle outs=%b stall=%0d want 00111100000 stall=0", outs, stall_cnt);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_load_hit();
    do_reset();
    ex_dren = 1; dhit = 1; ihit = 1;
    @(negedge CLK);
    checks++;
    if (outs !== 11'b10_1111_000_00) begin
      $display("FAIL load_hit outs=%b want 10111100000", outs);
      errors++;
    end
    next_cycle();
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00) begin
      $display("FAIL load_hit_still_run outs=%b want 00111100000", outs);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_store_miss();
    do_reset();
    ex_dwen = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (outs !== 11'b01_0000_000_00) begin
        $display("FAIL store_miss_c%0d outs=%b want 01000000000", i, outs);
        errors++;
      end
      next_cycle();
    end
    dhit = 1;
    @(negedge CLK);
    checks++;
    if (outs !== 11'b01_1111_000_00) begin
      $display("FAIL store_miss_adv outs=%b want 01111100000", outs);
      errors++;
    end
    next_cycle();
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00 || stall_cnt !== MISS_CNT) begin
      $display("FAIL store_miss_after outs=%b stall=%0d want 00111100000 stall=%0d",
               outs, stall_cnt, MISS_CNT);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_ihit_bubble();
    do_reset();
    ihit = 0;
    @(negedge CLK);
    checks++;
    if ({ifid_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, exmem_flush, pc_redirect} !== 7'b0110100) begin
      $display("FAIL ihit_bubble got=%b want 0110100",
               {ifid_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, exmem_flush, pc_redirect});
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch = 1; ihit = 0;
    @(negedge CLK);
    checks++;
    if ({ifid_flush, idex_flush, exmem_flush, pc_redirect, ifid_wen, memwb_wen} !== 6'b111101) begin
      $display("FAIL branch_flush got=%b want 111101",
               {ifid_flush, idex_flush, exmem_flush, pc_redirect, ifid_wen, memwb_wen});
      errors++;
    end
    next_cycle();
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00) begin
      $display("FAIL branch_one_cycle outs=%b want 00111100000", outs);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_jreg_miss();
    do_reset();
    ex_jreg = 1; ex_dren = 1; dhit = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (outs !== 11'b10_0000_000_00) begin
        $display("FAIL jreg_wait_c%0d outs=%b want 10000000000", i, outs);
        errors++;
      end
      next_cycle();
    end
    dhit = 1;
    @(negedge CLK);
    checks++;
    if ({dmemREN, ifid_flush, idex_flush, exmem_flush, pc_redirect, memwb_wen} !== 6'b111111) begin
      $display("FAIL jreg_dhit got=%b want 111111",
               {dmemREN, ifid_flush, idex_flush, exmem_flush, pc_redirect, memwb_wen});
      errors++;
    end
    next_cycle();
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00) begin
      $display("FAIL jreg_after outs=%b want 00111100000", outs);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_halt();
    do_reset();
    ex_halt = 1; ihit = 1;
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00) begin
      $display("FAIL halt_adv outs=%b want 00111100000", outs);
      errors++;
    end
    next_cycle();
    idle();
    ex_dren = 1; dhit = 1; ex_branch = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (outs !== 11'b00_0000_000_01) begin
        $display("FAIL halt_sticky_c%0d outs=%b want 00000000001", i, outs);
        errors++;
      end
      next_cycle();
    end
    RST = 1;
    @(negedge CLK);
    checks++;
    if (outs !== 11'b0) begin
      $display("FAIL halt_rst_cycle outs=%b want 0", outs);
      errors++;
    end
    next_cycle();
    RST = 0;
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00) begin
      $display("FAIL halt_cleared outs=%b want 00111100000", outs);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_halt_xfer();
    do_reset();
    ex_halt = 1; ex_jtype = 1;
    @(negedge CLK);
    checks++;
    if ({ifid_flush, idex_flush, exmem_flush, pc_redirect, memwb_wen, halt} !== 6'b111110) begin
      $display("FAIL halt_xfer got=%b want 111110",
               {ifid_flush, idex_flush, exmem_flush, pc_redirect, memwb_wen, halt});
      errors++;
    end
    next_cycle();
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_0000_000_01) begin
      $display("FAIL halt_xfer_halted outs=%b want 00000000001", outs);
      errors++;
    end
    next_cycle();
  endtask

  task automatic test_rst_memwait();
    do_reset();
    ex_dren = 1; dhit = 0;
    next_cycle();
    RST = 1;
    @(negedge CLK);
    checks++;
    if (outs !== 11'b0 || stall_cnt !== '0) begin
      $display("FAIL rst_memwait_cycle outs=%b stall=%0d want 0 0", outs, stall_cnt);
      errors++;
    end
    next_cycle();
    RST = 0;
    idle();
    @(negedge CLK);
    checks++;
    if (outs !== 11'b00_1111_000_00 || stall_cnt !== '0) begin
      $display("FAIL rst_memwait_run outs=%b stall=%0d want 00111100000 stall=0", outs, stall_cnt);
      errors++;
    end
    next_cycle();
  endtask

  initial begin
    idle();
    RST = 1;
    #1;
    test_reset();
    test_load_hit();
    test_store_miss();
    test_ihit_bubble();
    test_branch();
    test_jreg_miss();
    test_halt();
    test_halt_xfer();
    test_rst_memwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without summary");
    $fatal(1);
  end

endmodule
